ifetch_stage: RTL and testbench

//   Instruction-fetch stage plus IF/ID pipeline register of the 5-stage RV32I pipeline.
//   - Holds the PC and drives the combinational IROM address.
//   - Latches {inst, pc, pc+4} into IF/ID; the decode stage reads them next cycle.
//   - Honours a stall from the hazard unit and a redirect (taken branch/jump) from EX.

---
 rtl/ifetch_stage.sv | 64 ++++++
 tb/tb_ifetch_stage.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/ifetch_stage.sv
// Instruction-fetch stage and IF/ID pipeline register for the 5-stage RV32I pipeline.
// Optional fetch/bubble performance counters are enabled with `define IF_PERF_CNT_EN.
module ifetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic [31:0] irom_addr,
   input  logic [31:0] irom_inst,
   output logic [31:0] id_inst,
   output logic [31:0] id_pc,
   output logic [31:0] id_pc4,
`ifdef IF_PERF_CNT_EN
   output logic [31:0] perf_fetch,
   output logic [31:0] perf_bubble,
`endif
   output logic        id_valid
);

   logic [31:0] pc;
   logic [31:0] pc_plus4;

   assign pc_plus4  = pc + 32'd4;
   assign irom_addr = pc;

   // Redirect wins over stall: a stalled instruction on the wrong path is squashed.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc       <= RESET_PC;
         id_inst  <= NOP_INST;
         id_pc    <= '0;
         id_pc4   <= '0;
         id_valid <= 1'b0;
      end else if (redirect) begin
         pc       <= {redirect_pc[31:2], 2'b00};
         id_inst  <= NOP_INST;
         id_valid <= 1'b0;
      end else if (!stall) begin
         pc       <= pc_plus4;
         id_inst  <= irom_inst;
         id_pc    <= pc;
         id_pc4   <= pc_plus4;
         id_valid <= 1'b1;
      end
   end

`ifdef IF_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         perf_fetch  <= '0;
         perf_bubble <= '0;
      end else if (redirect || stall) begin
         perf_bubble <= perf_bubble + 32'd1;
      end else begin
         perf_fetch  <= perf_fetch + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_ifetch_stage.sv
// Directed self-checking bench for ifetch_stage; IROM word(A) = A ^ 32'hA5A5_0000.
// A second instance with RESET_PC = 32'hFFFF_FFFC exercises PC wrap-around.
module tb_ifetch_stage;

   logic        clk = 1'b0;
   logic        rst_n, stall, redirect;
   logic [31:0] redirect_pc;
   logic [31:0] irom_addr, irom_inst, id_inst, id_pc, id_pc4;
   logic        id_valid;
   logic        rst2_n;
   logic [31:0] irom_addr2, irom_inst2, id_inst2, id_pc2, id_pc4_2;
   logic        id_valid2;
`ifdef IF_PERF_CNT_EN
   logic [31:0] perf_fetch, perf_bubble, perf_fetch2, perf_bubble2;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   assign irom_inst  = irom_addr  ^ 32'hA5A5_0000;
   assign irom_inst2 = irom_addr2 ^ 32'hA5A5_0000;

   ifetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INST(32'h0000_0013)) dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
      .redirect_pc(redirect_pc), .irom_addr(irom_addr), .irom_inst(irom_inst),
      .id_inst(id_inst), .id_pc(id_pc), .id_pc4(id_pc4),
`ifdef IF_PERF_CNT_EN
      .perf_fetch(perf_fetch), .perf_bubble(perf_bubble),
`endif
      .id_valid(id_valid)
   );

   ifetch_stage #(.RESET_PC(32'hFFFF_FFFC), .NOP_INST(32'h0000_0013)) dut_wrap (
      .clk(clk), .rst_n(rst2_n), .stall(1'b0), .redirect(1'b0),
      .redirect_pc(32'h0), .irom_addr(irom_addr2), .irom_inst(irom_inst2),
      .id_inst(id_inst2), .id_pc(id_pc2), .id_pc4(id_pc4_2),
`ifdef IF_PERF_CNT_EN
      .perf_fetch(perf_fetch2), .perf_bubble(perf_bubble2),
`endif
      .id_valid(id_valid2)
   );

   // Advance one posedge and settle 1ns past it before sampling or driving.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; rst2_n = 1'b0; stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h40;
      step(); step();
      n_cmp++; if (irom_addr !== 32'h0) begin n_bad++; $display("FAIL rst_addr got %h want %h", irom_addr, 32'h0); end
      n_cmp++; if (id_inst !== 32'h13) begin n_bad++; $display("FAIL rst_inst got %h want %h", id_inst, 32'h13); end
      n_cmp++; if (id_pc !== 32'h0 || id_pc4 !== 32'h0) begin n_bad++; $display("FAIL rst_pc got %h/%h want 0/0", id_pc, id_pc4); end
      n_cmp++; if (id_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got %b want 0", id_valid); end
      rst_n = 1'b1; stall = 1'b0; redirect = 1'b0;
   endtask

   task automatic test_fetch();
      n_cmp++; if (id_valid !== 1'b0 || id_inst !== 32'h13) begin n_bad++; $display("FAIL first_cycle got %b/%h want 0/00000013", id_valid, id_inst); end
      step();
      n_cmp++; if (irom_addr !== 32'h4) begin n_bad++; $display("FAIL fetch_addr1 got %h want %h", irom_addr, 32'h4); end
      n_cmp++; if (id_inst !== 32'hA5A5_0000 || id_pc !== 32'h0 || id_pc4 !== 32'h4 || id_valid !== 1'b1) begin
         n_bad++; $display("FAIL fetch_w0 got %h/%h/%h/%b want a5a50000/0/4/1", id_inst, id_pc, id_pc4, id_valid); end
      step();
      n_cmp++; if (irom_addr !== 32'h8 || id_inst !== 32'hA5A5_0004 || id_pc !== 32'h4) begin
         n_bad++; $display("FAIL fetch_w4 got %h/%h/%h want 8/a5a50004/4", irom_addr, id_inst, id_pc); end
      step(); step();
      n_cmp++; if (irom_addr !== 32'h10 || id_pc !== 32'hC || id_inst !== 32'hA5A5_000C) begin
         n_bad++; $display("FAIL fetch_wc got %h/%h/%h want 10/c/a5a5000c", irom_addr, id_pc, id_inst); end
   endtask

   task automatic test_stall();
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         n_cmp++; if (irom_addr !== 32'h10 || id_pc !== 32'hC || id_inst !== 32'hA5A5_000C || id_valid !== 1'b1) begin
            n_bad++; $display("FAIL stall_hold%0d got %h/%h/%h/%b want 10/c/a5a5000c/1", i, irom_addr, id_pc, id_inst, id_valid); end
      end
      stall = 1'b0;
      step();
      n_cmp++; if (irom_addr !== 32'h14 || id_pc !== 32'h10 || id_inst !== 32'hA5A5_0010) begin
         n_bad++; $display("FAIL stall_release got %h/%h/%h want 14/10/a5a50010", irom_addr, id_pc, id_inst); end
      step(); step(); step();
      n_cmp++; if (irom_addr !== 32'h20 || id_pc !== 32'h1C) begin
         n_bad++; $display("FAIL stall_after got %h/%h want 20/1c", irom_addr, id_pc); end
   endtask

   task automatic test_redirect();
      redirect = 1'b1; redirect_pc = 32'h100;
      step();
      n_cmp++; if (irom_addr !== 32'h100) begin n_bad++; $display("FAIL redir_addr got %h want %h", irom_addr, 32'h100); end
      n_cmp++; if (id_valid !== 1'b0 || id_inst !== 32'h13 || id_pc !== 32'h1C || id_pc4 !== 32'h20) begin
         n_bad++; $display("FAIL redir_bubble got %b/%h/%h/%h want 0/13/1c/20", id_valid, id_inst, id_pc, id_pc4); end
      redirect = 1'b0;
      step();
      n_cmp++; if (irom_addr !== 32'h104 || id_pc !== 32'h100 || id_inst !== 32'hA5A5_0100 || id_valid !== 1'b1) begin
         n_bad++; $display("FAIL redir_target got %h/%h/%h/%b want 104/100/a5a50100/1", irom_addr, id_pc, id_inst, id_valid); end
   endtask

   task automatic test_redirect_stall();
      redirect = 1'b1; stall = 1'b1; redirect_pc = 32'h203;
      step();
      n_cmp++; if (irom_addr !== 32'h200 || id_valid !== 1'b0 || id_inst !== 32'h13 || id_pc !== 32'h100) begin
         n_bad++; $display("FAIL redir_stall got %h/%b/%h/%h want 200/0/13/100", irom_addr, id_valid, id_inst, id_pc); end
      redirect = 1'b0; stall = 1'b0;
      step();
      n_cmp++; if (irom_addr !== 32'h204 || id_pc !== 32'h200 || id_pc4 !== 32'h204 || id_valid !== 1'b1) begin
         n_bad++; $display("FAIL redir_stall_next got %h/%h/%h/%b want 204/200/204/1", irom_addr, id_pc, id_pc4, id_valid); end
   endtask

   task automatic test_reset_mid();
      rst_n = 1'b0; stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h300;
      step();
      n_cmp++; if (irom_addr !== 32'h0 || id_valid !== 1'b0 || id_pc !== 32'h0 || id_inst !== 32'h13) begin
         n_bad++; $display("FAIL reset_mid got %h/%b/%h/%h want 0/0/0/13", irom_addr, id_valid, id_pc, id_inst); end
      rst_n = 1'b1; stall = 1'b0; redirect = 1'b0;
      step();
      n_cmp++; if (irom_addr !== 32'h4 || id_pc !== 32'h0 || id_valid !== 1'b1) begin
         n_bad++; $display("FAIL reset_mid_next got %h/%h/%b want 4/0/1", irom_addr, id_pc, id_valid); end
   endtask

   task automatic test_wrap();
      rst2_n = 1'b0;
      step();
      n_cmp++; if (irom_addr2 !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_rst got %h want fffffffc", irom_addr2); end
      rst2_n = 1'b1;
      step();
      n_cmp++; if (irom_addr2 !== 32'h0 || id_pc2 !== 32'hFFFF_FFFC || id_pc4_2 !== 32'h0 || id_inst2 !== 32'h5A5A_FFFC || id_valid2 !== 1'b1) begin
         n_bad++; $display("FAIL wrap_first got %h/%h/%h/%h/%b want 0/fffffffc/0/5a5afffc/1", irom_addr2, id_pc2, id_pc4_2, id_inst2, id_valid2); end
      step();
      n_cmp++; if (irom_addr2 !== 32'h4 || id_pc2 !== 32'h0 || id_pc4_2 !== 32'h4) begin
         n_bad++; $display("FAIL wrap_second got %h/%h/%h want 4/0/4", irom_addr2, id_pc2, id_pc4_2); end
   endtask

`ifdef IF_PERF_CNT_EN
   task automatic test_perf();
      rst_n = 1'b0; stall = 1'b0; redirect = 1'b0;
      step();
      n_cmp++; if (perf_fetch !== 32'h0 || perf_bubble !== 32'h0) begin n_bad++; $display("FAIL perf_rst got %0d/%0d want 0/0", perf_fetch, perf_bubble); end
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) step();
      stall = 1'b1;
      for (int i = 0; i < 3; i++) step();
      stall = 1'b0; redirect = 1'b1; redirect_pc = 32'h80;
      for (int i = 0; i < 2; i++) step();
      redirect = 1'b0;
      n_cmp++; if (perf_fetch !== 32'd10 || perf_bubble !== 32'd5) begin n_bad++; $display("FAIL perf_count got %0d/%0d want 10/5", perf_fetch, perf_bubble); end
      rst_n = 1'b0;
      step();
      n_cmp++; if (perf_fetch !== 32'h0 || perf_bubble !== 32'h0) begin n_bad++; $display("FAIL perf_clear got %0d/%0d want 0/0", perf_fetch, perf_bubble); end
      rst_n = 1'b1;
   endtask
`endif

   initial begin
      rst_n = 1'b0; rst2_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
      #1;
      test_reset();
      test_fetch();
      test_stall();
      test_redirect();
      test_redirect_stall();
      test_reset_mid();
      test_wrap();
`ifdef IF_PERF_CNT_EN
      test_perf();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
